i2c_mem_slave: RTL
==================

// Module: i2c_mem_slave
// PURPOSE
//  I2C responder (slave end of the I2C master modport) that exposes an 8-bit-addressed byte memory over
//  the bus. It oversamples SCL/SDA on the system clock, matches a 7-bit device address and keeps a byte
//  pointer that auto-increments. It drives reads/writes on the slave side of I2C_Memory_Bus.
//  No clock stretching. SCL half-period >= SYNC_STAGES+MEM_RD_LATENCY+4 clk cycles (bench guarantees).
// PARAMETERS
//  SLAVE_ADDR      7'h42  7-bit device address answered with ACK
//  SYNC_STAGES     2      flops in each SCL/SDA input synchronizer (>=2)
//  MEM_RD_LATENCY  1      clk cycles from mem_rden pulse to valid mem_rdata (1..3)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset      in   1  asynchronous, active-high reset
//  scl_in     in   1  SCL pad input (async)
//  sda_in     in   1  SDA pad input (async)
//  sda_oe     out  1  1 = pull SDA low (open-drain); 0 = release
//  mem_ce     out  1  memory chip enable, high with any wren/rden pulse
//  mem_wren   out  1  one-cycle write strobe
//  mem_rden   out  1  one-cycle read strobe
//  mem_addr   out  8  memory byte address (= pointer)
//  mem_wdata  out  8  write data
//  mem_rdata  in   8  read data, valid MEM_RD_LATENCY cycles after mem_rden
//  busy       out  1  1 from address match until STOP/mismatch/NACK-release
// BEHAVIOUR
//  - Reset (async assert, any state): state=IDLE, pointer=0, sda_oe=0, mem_* strobes=0, mem_addr=0,
//    mem_wdata=0, busy=0, shift reg and bit counter=0. Reset mid-transfer drops transaction; SDA released.
//  - Inputs pass SYNC_STAGES flops; edges detected on synced values. START = SDA fall while SCL high;
//    STOP = SDA rise while SCL high. Data bits sampled on SCL rise, MSB first; sda_oe changes only
//    1 clk after a synced SCL fall.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
//  - START in any state (incl. repeated START) -> ADDR, bit counter=0. STOP in any state -> IDLE,
//    sda_oe=0, busy=0. Pointer retained across transactions.
//  - ADDR: after 8 bits, if byte[7:1]==SLAVE_ADDR -> ADDR_ACK, busy=1, else -> WAIT_STOP (no ACK).
//    R/W=1: issue read fetch of mem[pointer] on 8th SCL rise (+1 clk); latch mem_rdata into tx shifter.
//  - *_ACK: sda_oe=1 from SCL fall after bit 8 until SCL fall after bit 9 (ACK clock).
//  - Write path: ADDR_ACK(W) -> PTR; 8 bits -> pointer=byte -> PTR_ACK -> WDATA. WDATA 8 bits ->
//    mem_addr=pointer, mem_wdata=byte, mem_wren=mem_ce=1 for 1 clk after 8th SCL rise; pointer+1
//    -> WDATA_ACK -> WDATA. Every written byte is ACKed.
//  - Read path: ADDR_ACK(R) -> RDATA; slave drives sda_oe=~bit (MSB first) from each SCL fall;
//    pointer+1 after byte. RDATA_ACK: sda_oe=0, sample master bit on 9th SCL rise.
//    ACK(0) -> fetch mem[pointer] (rden 1 clk), -> RDATA. NACK(1) -> WAIT_STOP, busy=0.
//  - WAIT_STOP: sda_oe=0, ignore bits; leaves only on START/STOP.
//  - Pointer arithmetic: 8-bit, 8'hFF+1 wraps to 8'h00 (read and write).
//  - Fetch/write never overlap: at most one mem strobe per byte; mem_ce low when no strobe.
//  - START/STOP coinciding with a sampling SCL edge: START/STOP wins, bit discarded.
//  - Glitch on SDA while SCL high outside START/STOP definition is treated as START/STOP.
// TESTING
//  1 W to 0x42: ptr 0x10, data 0xA5,0x3C -> ACK x4; mem[0x10]=A5, mem[0x11]=3C, 2 wren pulses, ptr=0x12
//  2 addr 0x43 write -> no ACK (sda_oe=0 throughout), no mem strobes, busy=0, ptr unchanged
//  3 W ptr 0x20, Sr, R 3 bytes (ACK,ACK,NACK) with mem[20..22]=11,22,33 -> SDA bytes 11,22,33; WAIT_STOP
//  4 W ptr 0xFF, data 0x01,0x02 -> mem[FF]=01, mem[00]=02, ptr=0x01 (wrap)
//  5 reset asserted mid data-byte of write -> sda_oe=0 next cycle, no wren, ptr=0; next txn ACKs normally
//  6 STOP after 4 bits of data byte -> IDLE, no wren; following START+addr 0x42 ACKed

Source files
------------

// File: rtl/i2c_mem_slave.sv
`default_nettype none
// ============================================================================
// i2c_mem_slave : I2C responder exposing an 8-bit-addressed byte memory with an
//                 auto-incrementing byte pointer.
// Revision      : 1.0
// ============================================================================
module i2c_mem_slave #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h42,
  parameter int         SYNC_STAGES    = 2,
  parameter int         MEM_RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       mem_ce,
  output logic       mem_wren,
  output logic       mem_rden,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  localparam logic [3:0] c_IDLE      = 4'd0;
  localparam logic [3:0] c_ADDR      = 4'd1;
  localparam logic [3:0] c_ADDR_ACK  = 4'd2;
  localparam logic [3:0] c_PTR       = 4'd3;
  localparam logic [3:0] c_PTR_ACK   = 4'd4;
  localparam logic [3:0] c_WDATA     = 4'd5;
  localparam logic [3:0] c_WDATA_ACK = 4'd6;
  localparam logic [3:0] c_RDATA     = 4'd7;
  localparam logic [3:0] c_RDATA_ACK = 4'd8;
  localparam logic [3:0] c_WAIT_STOP = 4'd9;

  // Countdown loaded at the fetch strobe; read data is captured when it reaches 1.
  localparam logic [2:0] c_RD_WAIT = 3'(MEM_RD_LATENCY + 1);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic [3:0]             r_state;
  logic [3:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [7:0]             r_tx;
  logic [7:0]             r_ptr;
  logic                   r_rw;
  logic [2:0]             r_rd_wait;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
  assign w_byte     = {r_shift, w_sda};
  assign mem_ce     = mem_wren | mem_rden;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= c_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 7'd0;
      r_tx       <= 8'd0;
      r_ptr      <= 8'd0;
      r_rw       <= 1'b0;
      r_rd_wait  <= 3'd0;
      sda_oe     <= 1'b0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      mem_addr   <= 8'd0;
      mem_wdata  <= 8'd0;
      busy       <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;

      if (r_rd_wait != 3'd0) begin
        r_rd_wait <= r_rd_wait - 3'd1;
        if (r_rd_wait == 3'd1) begin
          r_tx <= mem_rdata;
        end
      end

      // Bus conditions take priority over any bit activity in the same cycle.
      if (w_start) begin
        r_state   <= c_ADDR;
        r_bit_cnt <= 4'd0;
        r_shift   <= 7'd0;
        sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state   <= c_IDLE;
        r_bit_cnt <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          c_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              if (r_bit_cnt == 4'd7) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  r_state   <= c_ADDR_ACK;
                  r_bit_cnt <= 4'd8;
                  busy      <= 1'b1;
                  r_rw      <= w_byte[0];
                  if (w_byte[0]) begin
                    mem_rden  <= 1'b1;
                    mem_addr  <= r_ptr;
                    r_rd_wait <= c_RD_WAIT;
                  end
                end else begin
                  r_state   <= c_WAIT_STOP;
                  r_bit_cnt <= 4'd0;
                  busy      <= 1'b0;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          c_ADDR_ACK, c_PTR_ACK, c_WDATA_ACK: begin
            // Count 8 marks the ACK low phase, 9 the ACK clock high phase.
            if (w_scl_fall && r_bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
            end else if (w_scl_rise && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd9;
            end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
              r_bit_cnt <= 4'd0;
              if (r_state == c_ADDR_ACK && r_rw) begin
                sda_oe  <= ~r_tx[7];
                r_tx    <= {r_tx[6:0], 1'b0};
                r_state <= c_RDATA;
              end else begin
                sda_oe  <= 1'b0;
                r_state <= (r_state == c_ADDR_ACK) ? c_PTR : c_WDATA;
              end
            end
          end

          c_PTR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              if (r_bit_cnt == 4'd7) begin
                r_ptr     <= w_byte;
                r_state   <= c_PTR_ACK;
                r_bit_cnt <= 4'd8;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          c_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              if (r_bit_cnt == 4'd7) begin
                mem_wren  <= 1'b1;
                mem_addr  <= r_ptr;
                mem_wdata <= w_byte;
                r_ptr     <= r_ptr + 8'd1;
                r_state   <= c_WDATA_ACK;
                r_bit_cnt <= 4'd8;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          c_RDATA: begin
            if (w_scl_fall && r_bit_cnt < 4'd8) begin
              sda_oe <= ~r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end else if (w_scl_rise) begin
              if (r_bit_cnt == 4'd7) begin
                r_ptr     <= r_ptr + 8'd1;
                r_state   <= c_RDATA_ACK;
                r_bit_cnt <= 4'd8;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          c_RDATA_ACK: begin
            if (w_scl_fall && r_bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
            end else if (w_scl_rise && r_bit_cnt == 4'd8) begin
              if (!w_sda) begin
                mem_rden  <= 1'b1;
                mem_addr  <= r_ptr;
                r_rd_wait <= c_RD_WAIT;
                r_bit_cnt <= 4'd9;
              end else begin
                r_state   <= c_WAIT_STOP;
                r_bit_cnt <= 4'd0;
                busy      <= 1'b0;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
              sda_oe    <= ~r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= 4'd0;
              r_state   <= c_RDATA;
            end
          end

          c_IDLE, c_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            r_state <= c_IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
